// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - word-by-word copy engine driving a single-port RAM
module ram_copy_engine #(
    parameter int ADDRESS_SIZE = 10,
    parameter int DATA_SIZE    = 10,
    parameter int MEMORY_SIZE  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDRESS_SIZE-1:0] src_addr,
    input  logic [ADDRESS_SIZE-1:0] dst_addr,
    input  logic [ADDRESS_SIZE:0]   length,
    output logic                    busy,
    output logic                    done,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]    mem_wdata,
    output logic                    mem_write,
    output logic                    mem_cs,
    input  logic [DATA_SIZE-1:0]    mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDRESS_SIZE:0] MAX_LEN = (ADDRESS_SIZE+1)'(MEMORY_SIZE);

    state_t                  state, state_next;
    logic [ADDRESS_SIZE-1:0] src_q, dst_q;
    logic [ADDRESS_SIZE:0]   len_q, cnt_q, cnt_inc;
    logic [DATA_SIZE-1:0]    hold_q;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ:  state_next = S_WRITE;
            S_WRITE: state_next = (cnt_inc == len_q) ? S_DONE : S_READ;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start && length != '0) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        // Oversized requests saturate to a full-memory copy
                        len_q <= (length > MAX_LEN) ? MAX_LEN : length;
                        cnt_q <= '0;
                    end
                end
                S_READ:  hold_q <= mem_rdata;
                S_WRITE: cnt_q  <= cnt_inc;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state == S_READ) || (state == S_WRITE);
        done      = (state == S_DONE);
        mem_cs    = busy;
        mem_write = (state == S_WRITE);
        mem_wdata = hold_q;
        mem_addr  = '0;
        // Address adds drop the carry, giving modulo-2^ADDRESS_SIZE wrap
        if (state == S_READ) begin
            mem_addr = src_q + cnt_q[ADDRESS_SIZE-1:0];
        end else if (state == S_WRITE) begin
            mem_addr = dst_q + cnt_q[ADDRESS_SIZE-1:0];
        end
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb/tb_ram_copy_engine.sv - randomized self-checking bench for ram_copy_engine
module tb_ram_copy_engine;

    localparam int AW = 10;
    localparam int DW = 10;
    localparam int MS = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, mem_write, mem_cs;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] ram       [MS];
    logic [DW-1:0] mem_model [MS];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    ram_copy_engine #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MEMORY_SIZE(MS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_cs(mem_cs),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle; the RAM commits a write seen at mid-cycle
    task automatic tick();
        @(negedge clk);
        if (mem_cs === 1'b1 && mem_write === 1'b1) ram[mem_addr] = mem_wdata;
    endtask

    task automatic poke(input int a, input logic [DW-1:0] v);
        ram[a] = v;
        mem_model[a] = v;
    endtask

    task automatic model_copy(input int s, input int d, input int n);
        for (int k = 0; k < n; k++) mem_model[(d + k) % MS] = mem_model[(s + k) % MS];
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int k = 0; k < MS; k++) if (ram[k] !== mem_model[k]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic run_copy(input string tag, input int s, input int d, input int n, input bit inject);
        int busy_cnt = 0, done_cnt = 0, done_cyc = 0, cs_cnt = 0, first_busy = 0;
        src_addr = AW'(s);
        dst_addr = AW'(d);
        length   = (AW+1)'(n);
        start    = 1'b1;
        for (int c = 1; c <= 2 * n + 4; c++) begin
            tick();
            start = inject && (c == 2 || c == 7);
            if (start) begin
                src_addr = AW'($urandom);
                dst_addr = AW'($urandom);
                length   = (AW+1)'($urandom_range(1, 30));
            end
            if (busy === 1'b1) begin
                busy_cnt++;
                if (first_busy == 0) first_busy = c;
            end
            if (mem_cs === 1'b1) cs_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        start = 1'b0;
        model_copy(s, d, n);
        check({tag, "_busy_cycles"}, busy_cnt, 2 * n);
        check({tag, "_cs_cycles"}, cs_cnt, 2 * n);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_cyc, 2 * n + 1);
        check({tag, "_first_busy"}, first_busy, (n > 0) ? 1 : 0);
        compare_mem({tag, "_mem"});
    endtask

    initial begin
        int changed;
        for (int k = 0; k < MS; k++) poke(k, DW'($urandom));

        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", mem_cs, 0);
        check("rst_write", mem_write, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) poke(10 + k, DW'(k + 1));
        run_copy("basic", 10, 200, 4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("basic_dst", ram[200 + k], k + 1);
            check("basic_src", ram[10 + k], k + 1);
        end

        run_copy("zero_len", 77, 99, 0, 1'b0);

        poke(1022, 5); poke(1023, 6); poke(0, 7); poke(1, 8);
        run_copy("wrap_src", 1022, 500, 4, 1'b0);
        for (int k = 0; k < 4; k++) check("wrap_src_word", ram[500 + k], k + 5);
        run_copy("wrap_dst", 500, 1023, 2, 1'b0);
        check("wrap_dst_1023", ram[1023], 5);
        check("wrap_dst_0", ram[0], 6);

        run_copy("ignored_start", 40, 600, 6, 1'b1);

        // Abort after the third write of an 8-word copy
        for (int k = 0; k < 8; k++) poke(300 + k, ram[700 + k] ^ DW'(1));
        src_addr = AW'(300);
        dst_addr = AW'(700);
        length   = (AW+1)'(8);
        start    = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cs", mem_cs, 0);
        changed = 0;
        for (int k = 0; k < 8; k++) if (ram[700 + k] !== (ram[300 + k] ^ DW'(1))) changed++;
        check("abort_changed_words", changed, 3);
        model_copy(300, 700, 3);
        compare_mem("abort_mem");
        rst = 1'b0;
        tick();
        run_copy("after_abort", 300, 700, 8, 1'b0);

        poke(0, 10'h0A); poke(1, 10'h0B); poke(2, 10'h0C); poke(3, 10'h0D);
        run_copy("smear", 0, 1, 3, 1'b0);
        for (int k = 1; k <= 3; k++) check("smear_word", ram[k], 10'h0A);

        for (int t = 0; t < 8; t++) begin
            run_copy("random", $urandom_range(0, MS - 1), $urandom_range(0, MS - 1),
                     $urandom_range(1, 40), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
        run_copy("full_mem", $urandom_range(0, MS - 1), $urandom_range(0, MS - 1), MS, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
Initiator/master for the single-port RAM block. It drives the RAM's address, write-data, write-strobe and chip-select pins, and reads its combinational data output. On a start pulse it copies LENGTH consecutive words from a source address to a destination address, one word every two cycles. It sits between control logic (FSM or CPU register) and the RAM instance, and reports busy/done to the control logic.

Parameters:
ADDRESS_SIZE, 10, RAM address width; all address arithmetic is modulo 2^ADDRESS_SIZE.
DATA_SIZE, 10, RAM word width.
MEMORY_SIZE, 1024, RAM depth; must equal 2^ADDRESS_SIZE.

Ports:
clk  in  1  single clock; all state changes on its rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  request a copy; sampled only in IDLE.
src_addr  in  ADDRESS_SIZE  first source word address; sampled with start.
dst_addr  in  ADDRESS_SIZE  first destination word address; sampled with start.
length  in  ADDRESS_SIZE+1  number of words to copy, 0..MEMORY_SIZE; sampled with start.
busy  out  1  high while a copy is in progress (READ/WRITE states).
done  out  1  one-cycle pulse when a copy finishes.
mem_addr  out  ADDRESS_SIZE  to RAM address_1.
mem_wdata  out  DATA_SIZE  to RAM data_in_1.
mem_write  out  1  to RAM write_1.
mem_cs  out  1  to RAM chip_select_1.
mem_rdata  in  DATA_SIZE  from RAM data_out_1; combinational read, valid in the same cycle as mem_addr.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, READ, WRITE, DONE. All state and datapath registers are updated on the rising edge of clk.
- Reset: the state goes to IDLE. busy=0, done=0, mem_write=0, mem_cs=0, mem_addr=0, mem_wdata=0. The internal counter and the hold register clear to 0.
- Mid-operation reset: the copy aborts immediately and done is not pulsed. Words already written stay in the RAM.
- Output decode: all mem_* outputs, busy and done are decoded from registered state only. There are no combinational paths from start or the other request inputs.
- IDLE:
  - busy=0, mem_cs=0, mem_write=0.
  - start=1 with length>0: latch src, dst and length, clear the word counter i, then go to READ.
  - start=1 with length=0: go to DONE. No RAM access occurs.
- READ:
  - mem_cs=1, mem_write=0, mem_addr = src+i (mod 2^ADDRESS_SIZE).
  - At the clock edge, mem_rdata is captured into the hold register, then go to WRITE.
- WRITE:
  - mem_cs=1, mem_write=1, mem_addr = dst+i (mod), mem_wdata = hold.
  - At the clock edge, i increments. If i+1 == length, go to DONE; otherwise go to READ.
- DONE: done=1, busy=0, mem_cs=0, mem_write=0. Go to IDLE on the next edge.
- Timing:
  - With start sampled at edge T, busy is high for cycles T+1 .. T+2·length.
  - done is high in cycle T+2·length+1.
  - A new start is accepted no earlier than the edge that ends the DONE cycle + 1, i.e. in IDLE.
- start while busy or DONE: ignored, with no effect on the latched parameters.
- Address wrap-around: source and destination addresses wrap from MEMORY_SIZE-1 to 0.
- length = MEMORY_SIZE is legal. The counter is ADDRESS_SIZE+1 bits wide, so it cannot alias.
- Overlap: words are copied strictly in ascending order, read i then write i. With dst inside (src, src+length), earlier writes are re-read by later reads; this is the defined result (smear).
- mem_wdata is held at the hold register value in every state; it is don't-care outside WRITE but deterministic.

Test Plan:
- Basic copy: preload RAM[10..13] = 1,2,3,4; start with src=10, dst=200, length=4. Required: RAM[200..203] = 1,2,3,4; busy is high for exactly 8 cycles; done pulses once in cycle 9; RAM[10..13] is unchanged.
- Zero length: start with length=0. Required: mem_write and mem_cs stay 0, and done pulses in the cycle after start is sampled.
- Wrap-around: preload RAM[1022]=5, RAM[1023]=6, RAM[0]=7, RAM[1]=8; copy src=1022, dst=500, length=4. Required: RAM[500..503] = 5,6,7,8. Then copy src=500, dst=1023, length=2. Required: RAM[1023]=5 and RAM[0]=6.
- Ignored start: during a length=6 copy, pulse start with different parameters at cycles 2 and 7. Required: only the original copy executes, with one done pulse after 12 busy cycles.
- Reset mid-copy: assert rst after the 3rd write of a length=8 copy. Required: next cycle busy=0, done=0, mem_cs=0; exactly 3 destination words are modified; a following start works normally.
- Overlap smear: preload RAM[0..3] = A,B,C,D; copy src=0, dst=1, length=3. Required: RAM[1..3] = A,A,A.
